// File: rtl/stoch_decode_pkg.sv
// Shared types and sizing helpers for the signed stochastic matrix decoder.
package stoch_decode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } decode_state_t;

  // Window of N = 2^log_window samples spans -N..+N, so one extra magnitude bit plus sign.
  function automatic int acc_width(input int log_window);
    return log_window + 2;
  endfunction

endpackage

// File: rtl/stoch_signed_decode.sv
// Single-element signed up/down accumulator for a (p, m) stochastic bitstream pair.
module stoch_signed_decode
  import stoch_decode_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         en,
  input  logic         a_p,
  input  logic         a_m,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] acc_reg;

  // Two's-complement add/subtract; range is bounded by the window so no saturation is needed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      if (a_p && !a_m) begin
        acc_reg <= acc_reg + ONE;
      end else if (!a_p && a_m) begin
        acc_reg <= acc_reg - ONE;
      end
    end
  end

  assign y = acc_reg;

endmodule

// File: rtl/stoch_signed_decode_mat.sv
// Matrix of signed stochastic decoders sharing one window FSM, with a valid/ready result handshake.
module stoch_signed_decode_mat
  import stoch_decode_pkg::*;
#(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_COLS   = 2,
  parameter int LOG_WINDOW = 8
) (
  input  logic                                               CLK,
  input  logic                                               nRST,
  input  logic                                               start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                  X_p,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                  X_m,
  output logic                                               busy,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][LOG_WINDOW+1:0]  Y,
  output logic                                               valid,
  input  logic                                               ready
);

  localparam int ACC_W = acc_width(LOG_WINDOW);
  localparam logic [LOG_WINDOW-1:0] LAST = {LOG_WINDOW{1'b1}};
  localparam logic [LOG_WINDOW-1:0] STEP = {{(LOG_WINDOW-1){1'b0}}, 1'b1};

  decode_state_t         state_reg;
  logic [LOG_WINDOW-1:0] count_reg;
  logic                  acc_clr;
  logic                  acc_en;

  // Clear on any window start: from IDLE, or a back-to-back restart at handshake.
  assign acc_clr = start && ((state_reg == IDLE) || (state_reg == HOLD && ready));
  assign acc_en  = (state_reg == ACCUM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            count_reg <= '0;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          count_reg <= count_reg + STEP;
          if (count_reg == LAST) begin
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            count_reg <= '0;
            state_reg <= start ? ACCUM : IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
        end
      endcase
    end
  end

  assign busy  = (state_reg == ACCUM);
  assign valid = (state_reg == HOLD);

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      for (gj = 0; gj < NUM_COLS; gj++) begin : g_col
        stoch_signed_decode #(
          .W(ACC_W)
        ) u_elem (
          .CLK (CLK),
          .nRST(nRST),
          .clr (acc_clr),
          .en  (acc_en),
          .a_p (X_p[gi][gj]),
          .a_m (X_m[gi][gj]),
          .y   (Y[gi][gj])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_stoch_signed_decode_mat.sv
// Randomized self-checking bench: expected results are window sums of (p - m) per element.
module tb_stoch_signed_decode_mat;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int LW = 4;
  localparam int N  = 1 << LW;
  localparam int W  = LW + 2;

  logic                       CLK = 1'b0;
  logic                       nRST;
  logic                       start;
  logic                       ready;
  logic [R-1:0][C-1:0]        X_p;
  logic [R-1:0][C-1:0]        X_m;
  logic                       busy;
  logic                       valid;
  logic [R-1:0][C-1:0][W-1:0] Y;

  int vectors     = 0;
  int miscompares = 0;
  int exp_y [R][C];

  stoch_signed_decode_mat #(
    .NUM_ROWS  (R),
    .NUM_COLS  (C),
    .LOG_WINDOW(LW)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .start(start),
    .X_p  (X_p),
    .X_m  (X_m),
    .busy (busy),
    .Y    (Y),
    .valid(valid),
    .ready(ready)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_y(input string tag);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        check_val($sformatf("%s Y[%0d][%0d]", tag, r, c), int'($signed(Y[r][c])), exp_y[r][c]);
  endtask

  task automatic clear_exp();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        exp_y[r][c] = 0;
  endtask

  // Drive one sample vector for window position i and add its contribution to the model.
  task automatic drive_sample(input int mode, input int i);
    bit p, m;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        case (mode)
          0:       begin p = 1'b1; m = 1'b0; end
          1:       begin p = 1'b0; m = 1'b1; end
          2:       begin p = 1'b1; m = 1'b1; end
          default: begin p = 1'($urandom); m = 1'($urandom); end
        endcase
        if (mode == 3 && r == 0 && c == 0) begin
          p = (i % 2 == 0);
          m = 1'b0;
        end
        if (mode == 3 && r == 1 && c == 1) begin
          p = (i < 12);
          m = (i >= 12);
        end
        X_p[r][c] = p;
        X_m[r][c] = m;
        exp_y[r][c] += int'(p) - int'(m);
      end
    end
  endtask

  task automatic run_window(input int mode, input bit started);
    if (!started) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    clear_exp();
    check_val("busy after start", int'(busy), 1);
    check_val("valid after start", int'(valid), 0);
    check_y("cleared");
    for (int i = 0; i < N; i++) begin
      drive_sample(mode, i);
      start = 1'($urandom);
      ready = 1'($urandom);
      tick();
      if (i < N - 1) check_val("busy mid window", int'(busy), 1);
    end
    start = 1'b0;
    ready = 1'b0;
    check_val("valid at window end", int'(valid), 1);
    check_val("busy at window end", int'(busy), 0);
    check_y($sformatf("window mode %0d", mode));
  endtask

  task automatic hold_and_release(input bit b2b, input int hold_cycles);
    ready = 1'b0;
    for (int k = 0; k < hold_cycles; k++) begin
      X_p   = R*C'($urandom);
      X_m   = R*C'($urandom);
      start = 1'($urandom);
      tick();
      check_val("valid in hold", int'(valid), 1);
      check_y("hold");
    end
    ready = 1'b1;
    start = b2b;
    tick();
    ready = 1'b0;
    start = 1'b0;
    check_val("valid after handshake", int'(valid), 0);
    check_val("busy after handshake", int'(busy), int'(b2b));
  endtask

  initial begin
    nRST  = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    X_p   = '0;
    X_m   = '0;
    clear_exp();
    #12;
    check_val("reset busy", int'(busy), 0);
    check_val("reset valid", int'(valid), 0);
    check_y("reset");
    nRST = 1'b1;

    // ready while idle must not produce a result
    for (int k = 0; k < 3; k++) begin
      ready = 1'b1;
      X_p   = R*C'($urandom);
      tick();
      check_val("idle valid", int'(valid), 0);
      check_val("idle busy", int'(busy), 0);
    end
    ready = 1'b0;

    run_window(0, 1'b0); hold_and_release(1'b0, 3);
    run_window(1, 1'b0); hold_and_release(1'b0, 2);
    run_window(2, 1'b0); hold_and_release(1'b0, 1);
    run_window(3, 1'b0); hold_and_release(1'b1, 20);
    run_window(4, 1'b1); hold_and_release(1'b1, 0);
    run_window(4, 1'b1); hold_and_release(1'b0, 5);
    for (int k = 0; k < 6; k++) begin
      run_window(4, 1'b0);
      hold_and_release(1'($urandom), int'($urandom_range(0, 3)));
      if (busy) begin
        run_window(4, 1'b1);
        hold_and_release(1'b0, 1);
      end
    end

    // Reset in the middle of a window discards it
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_exp();
    for (int i = 0; i < 7; i++) begin
      drive_sample(4, i);
      tick();
    end
    #2;
    nRST = 1'b0;
    #1;
    clear_exp();
    check_val("midreset busy", int'(busy), 0);
    check_val("midreset valid", int'(valid), 0);
    check_y("midreset");
    #3;
    nRST = 1'b1;
    for (int k = 0; k < 20; k++) begin
      start = 1'b0;
      ready = 1'b1;
      X_p   = R*C'($urandom);
      X_m   = R*C'($urandom);
      tick();
      check_val("post reset valid", int'(valid), 0);
      check_val("post reset busy", int'(busy), 0);
    end
    ready = 1'b0;

    run_window(4, 1'b0); hold_and_release(1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
